// File: rtl/siphash_msg_packer.sv
// Byte-stream to 64-bit little-endian word packer with SipHash length padding, sequencing siphash_core.
// Optional SIPHASH_PACKER_LONG_EN adds long_in, latched at start and driven on core_long.
module siphash_msg_packer #(
  parameter int LEN_CTR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  input  logic                     in_last,
  input  logic                     in_empty,
`ifdef SIPHASH_PACKER_LONG_EN
  input  logic                     long_in,
`endif
  output logic                     core_initalize,
  output logic                     core_compress,
  output logic                     core_finalize,
  output logic                     core_long,
  output logic [63:0]              core_mi,
  input  logic                     core_ready,
  output logic                     busy,
  output logic                     done,
  output logic [LEN_CTR_WIDTH-1:0] msg_len
);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_SEND, S_TAIL, S_FIN, S_WAIT_FIN} state_t;

  state_t                   state_q, state_d;
  logic [63:0]              word_q, word_d, word_wr;
  logic [2:0]               idx_q, idx_d;
  logic [LEN_CTR_WIDTH-1:0] len_q, len_d, len_inc;
  logic                     tail_q, tail_d, final_q, final_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic                     init_q, init_d, comp_q, comp_d, fin_q, fin_d;
  logic                     long_q, long_d;
  logic                     core_go, beat;

  // Zero the unused bytes from position 'from' up to 6 and place the length byte at 7.
  function automatic logic [63:0] pad_word(input logic [63:0] w, input logic [3:0] from,
                                           input logic [7:0] len_byte);
    logic [63:0] r;
    r = w;
    for (int b = 0; b < 7; b++) begin
      if (b >= int'(from)) r[8*b +: 8] = 8'h00;
    end
    r[63:56] = len_byte;
    return r;
  endfunction

  // A command output still high blocks the next one, so core_ready is only trusted once the
  // core has had a cycle to drop it.
  assign core_go  = core_ready & ~(init_q | comp_q | fin_q);
  assign in_ready = (state_q == S_COLLECT);
  assign beat     = in_valid & in_ready;
  assign len_inc  = len_q + LEN_CTR_WIDTH'(1);

  always_comb begin
    word_wr                        = word_q;
    word_wr[{idx_q, 3'b000} +: 8]  = in_data;
  end

`ifdef SIPHASH_PACKER_LONG_EN
  logic long_sel;
  assign long_sel = long_in;
`else
  logic long_sel;
  assign long_sel = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    len_d   = len_q;
    tail_d  = tail_q;
    final_d = final_q;
    busy_d  = busy_q;
    long_d  = long_q;
    done_d  = 1'b0;
    init_d  = 1'b0;
    comp_d  = 1'b0;
    fin_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && core_go) begin
          init_d  = 1'b1;
          word_d  = 64'h0;
          idx_d   = 3'd0;
          len_d   = '0;
          tail_d  = 1'b0;
          final_d = 1'b0;
          busy_d  = 1'b1;
          long_d  = long_sel;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (beat) begin
          if (in_last && in_empty) begin
            word_d  = pad_word(word_q, {1'b0, idx_q}, 8'(len_q));
            final_d = 1'b1;
            idx_d   = 3'd0;
            state_d = S_SEND;
          end else begin
            len_d = len_inc;
            if (idx_q == 3'd7) begin
              word_d  = word_wr;
              tail_d  = in_last;
              idx_d   = 3'd0;
              state_d = S_SEND;
            end else if (in_last) begin
              word_d  = pad_word(word_wr, {1'b0, idx_q} + 4'd1, 8'(len_inc));
              final_d = 1'b1;
              idx_d   = 3'd0;
              state_d = S_SEND;
            end else begin
              word_d = word_wr;
              idx_d  = idx_q + 3'd1;
            end
          end
        end
      end
      S_SEND: begin
        if (core_go) begin
          comp_d = 1'b1;
          if (tail_q) begin
            tail_d  = 1'b0;
            state_d = S_TAIL;
          end else if (final_q) begin
            state_d = S_FIN;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_TAIL: begin
        word_d  = {8'(len_q), 56'h0};
        final_d = 1'b1;
        state_d = S_SEND;
      end
      S_FIN: begin
        if (core_go) begin
          fin_d   = 1'b1;
          state_d = S_WAIT_FIN;
        end
      end
      S_WAIT_FIN: begin
        if (core_go) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      word_q  <= 64'h0;
      idx_q   <= 3'd0;
      len_q   <= '0;
      tail_q  <= 1'b0;
      final_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
      comp_q  <= 1'b0;
      fin_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      tail_q  <= tail_d;
      final_q <= final_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      init_q  <= init_d;
      comp_q  <= comp_d;
      fin_q   <= fin_d;
      long_q  <= long_d;
    end
  end

  // The word register only changes at the end of the compress cycle, so it doubles as core_mi.
  assign core_mi        = word_q;
  assign core_initalize = init_q;
  assign core_compress  = comp_q;
  assign core_finalize  = fin_q;
  assign core_long      = long_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign msg_len        = len_q;

endmodule

// File: tb/tb_siphash_msg_packer.sv
// Self-checking bench for siphash_msg_packer: randomized messages against a padding/packing model.
module tb_siphash_msg_packer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, in_valid, in_last, in_empty, core_ready;
  logic [7:0]  in_data;
  logic        in_ready, core_initalize, core_compress, core_finalize, core_long, busy, done;
  logic [63:0] core_mi;
  logic [31:0] msg_len;
  logic        in_ready_w, init_w, comp_w, fin_w, long_w, busy_w, done_w;
  logic [63:0] core_mi_w;
  logic [8:0]  msg_len_w;
`ifdef SIPHASH_PACKER_LONG_EN
  logic        long_in;
`endif

  siphash_msg_packer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_empty(in_empty),
`ifdef SIPHASH_PACKER_LONG_EN
    .long_in(long_in),
`endif
    .core_initalize(core_initalize), .core_compress(core_compress), .core_finalize(core_finalize),
    .core_long(core_long), .core_mi(core_mi), .core_ready(core_ready), .busy(busy), .done(done),
    .msg_len(msg_len)
  );

  // Narrow length counter copy, used to observe counter wrap.
  siphash_msg_packer #(.LEN_CTR_WIDTH(9)) dut_w (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_data(in_data), .in_last(in_last), .in_empty(in_empty),
`ifdef SIPHASH_PACKER_LONG_EN
    .long_in(long_in),
`endif
    .core_initalize(init_w), .core_compress(comp_w), .core_finalize(fin_w),
    .core_long(long_w), .core_mi(core_mi_w), .core_ready(core_ready), .busy(busy_w), .done(done_w),
    .msg_len(msg_len_w)
  );

  // Core behaviour: ready drops after any command and returns after a random latency.
  logic        rdy_q, hold;
  int unsigned lat;
  assign core_ready = rdy_q & ~hold;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q <= 1'b1;
      lat   <= 0;
    end else if (core_initalize || core_compress || core_finalize) begin
      rdy_q <= 1'b0;
      lat   <= $urandom_range(1, 5);
    end else if (lat > 1) begin
      lat <= lat - 1;
    end else if (lat == 1) begin
      lat   <= 0;
      rdy_q <= 1'b1;
    end
  end

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  msg_q[$];
  int          fin_cnt, done_cnt, init_cnt, viol;
  logic        prev_pulse;
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_pulse = 1'b0;
    end else begin
      if ((core_initalize || core_compress || core_finalize) && prev_pulse) viol++;
      if ((core_initalize || core_compress || core_finalize) && !core_ready) viol++;
      if (core_compress) got_q.push_back(core_mi);
      if (core_compress && (core_mi !== core_mi_w || !comp_w)) viol++;
      if (core_finalize) fin_cnt++;
      if (done) done_cnt++;
      if (core_initalize) init_cnt++;
      prev_pulse = core_initalize || core_compress || core_finalize;
    end
  end

  // Reference: little-endian packing; last word carries length mod 256 in byte 7.
  task automatic build_expected();
    int n, nw;
    logic [63:0] w;
    exp_q.delete();
    n  = msg_q.size();
    nw = n / 8 + 1;
    for (int wi = 0; wi < nw; wi++) begin
      w = 64'h0;
      for (int b = 0; b < 8; b++)
        if (8 * wi + b < n) w[8*b +: 8] = msg_q[8 * wi + b];
      if (wi == nw - 1) w[63:56] = 8'(n % 256);
      exp_q.push_back(w);
    end
  endtask

  function automatic int first_bad();
    if (got_q.size() != exp_q.size()) return -2;
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic clear_mon();
    got_q.delete();
    fin_cnt = 0; done_cnt = 0; init_cnt = 0; viol = 0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
    in_data = 8'h0; hold = 1'b0;
`ifdef SIPHASH_PACKER_LONG_EN
    long_in = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_start(output bit ok);
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (busy) break;
    end
    start = 1'b0;
    ok = busy;
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic last, input logic empty,
                            input bit gaps, output bit ok);
    logic hs;
    in_valid = 1'b1; in_data = d; in_last = last; in_empty = empty;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk) hs = in_ready;
      @(posedge clk); #1;
      if (hs) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0; in_data = 8'($urandom);
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(output bit ok);
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) break;
    end
    ok = (done_cnt > 0);
  endtask

  // Starts, streams msg_q and waits for done; ok reports every bounded wait completed.
  task automatic run_msg(input int n, input bit empty_end, input bit incr, input bit gaps,
                         output bit ok);
    bit o;
    msg_q.delete();
    for (int k = 0; k < n; k++) msg_q.push_back(incr ? 8'(k) : 8'($urandom));
    clear_mon();
    do_start(o); ok = o;
    for (int k = 0; k < n; k++) begin
      drive_beat(msg_q[k], (k == n - 1) && !empty_end, 1'b0, gaps, o); ok &= o;
    end
    if (empty_end || n == 0) begin drive_beat(8'($urandom), 1'b1, 1'b1, gaps, o); ok &= o; end
    wait_done(o); ok &= o;
    build_expected();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; #2;
    checks++;
    if ({in_ready, core_initalize, core_compress, core_finalize, core_long, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {in_ready, core_initalize, core_compress, core_finalize, core_long, busy, done});
    end
    checks++;
    if (core_mi !== 64'h0) begin errors++; $display("FAIL reset_mi: got %h required 0", core_mi); end
    apply_reset();
    checks++;
    if (msg_len !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: msg_len %0d busy %b in_ready %b required 0 0 0", msg_len, busy, in_ready);
    end
  endtask

  task automatic test_empty();
    bit ok;
    run_msg(0, 1'b1, 1'b0, 1'b0, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL empty_handshake: got %b required 1", ok); end
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL empty_count: got %0d compresses required 1", got_q.size());
    end else if (got_q[0] !== 64'h0) begin
      errors++; $display("FAIL empty_mi: got %h required 0", got_q[0]);
    end
    checks++;
    if (fin_cnt != 1 || msg_len !== 32'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL empty_end: fin %0d msg_len %0d busy %b required 1 0 0", fin_cnt, msg_len, busy);
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL empty_protocol: got %0d violations required 0", viol); end
  endtask

  task automatic test_vectors();
    bit ok;
    run_msg(15, 1'b0, 1'b1, 1'b1, ok);
    checks++;
    if (!ok || got_q.size() != 2) begin
      errors++; $display("FAIL vec15_count: ok %b got %0d words required 2", ok, got_q.size());
    end else if (got_q[0] !== 64'h0706050403020100 || got_q[1] !== 64'h0f0e0d0c0b0a0908) begin
      errors++; $display("FAIL vec15_mi: got %h %h required 0706050403020100 0f0e0d0c0b0a0908", got_q[0], got_q[1]);
    end
    checks++;
    if (fin_cnt != 1 || msg_len !== 32'd15 || viol != 0) begin
      errors++; $display("FAIL vec15_end: fin %0d msg_len %0d viol %0d required 1 15 0", fin_cnt, msg_len, viol);
    end
    run_msg(8, 1'b0, 1'b1, 1'b0, ok);
    checks++;
    if (!ok || got_q.size() != 2) begin
      errors++; $display("FAIL vec8_count: ok %b got %0d words required 2", ok, got_q.size());
    end else if (got_q[0] !== 64'h0706050403020100 || got_q[1] !== 64'h0800000000000000) begin
      errors++; $display("FAIL vec8_mi: got %h %h required 0706050403020100 0800000000000000", got_q[0], got_q[1]);
    end
    checks++;
    if (msg_len !== 32'd8 || viol != 0) begin
      errors++; $display("FAIL vec8_end: msg_len %0d viol %0d required 8 0", msg_len, viol);
    end
  endtask

  task automatic test_random();
    bit ok;
    int n, bad;
    bit ee;
`ifdef SIPHASH_PACKER_LONG_EN
    logic lv;
`endif
    for (int it = 0; it < 8; it++) begin
      n  = $urandom_range(1, 40);
      ee = 1'($urandom_range(0, 1));
`ifdef SIPHASH_PACKER_LONG_EN
      lv = 1'($urandom); long_in = lv;
      fork
        begin @(posedge busy); #1 long_in = ~lv; end
      join_none
`endif
      run_msg(n, ee, 1'b0, 1'b1, ok);
      checks++;
      bad = first_bad();
      if (!ok) begin
        errors++; $display("FAIL rand%0d_handshake: timed out, n=%0d", it, n);
      end else if (bad == -2) begin
        errors++; $display("FAIL rand%0d_words: got %0d words required %0d (n=%0d)", it, got_q.size(), exp_q.size(), n);
      end else if (bad >= 0) begin
        errors++; $display("FAIL rand%0d_mi: word %0d got %h required %h", it, bad, got_q[bad], exp_q[bad]);
      end
      checks++;
      if (msg_len !== 32'(n) || fin_cnt != 1 || init_cnt != 1 || viol != 0) begin
        errors++;
        $display("FAIL rand%0d_end: msg_len %0d fin %0d init %0d viol %0d required %0d 1 1 0", it, msg_len, fin_cnt, init_cnt, viol, n);
      end
`ifdef SIPHASH_PACKER_LONG_EN
      checks++;
      if (core_long !== lv) begin errors++; $display("FAIL rand%0d_long: got %b required %b", it, core_long, lv); end
`endif
    end
  endtask

  task automatic test_backpressure();
    bit ok, o, stuck;
    int bad;
    msg_q.delete();
    for (int k = 0; k < 11; k++) msg_q.push_back(8'h10 + 8'(k));
    clear_mon();
    do_start(ok);
    repeat (2) begin @(posedge clk); #1; end
    hold = 1'b1;
    for (int k = 0; k < 8; k++) begin drive_beat(msg_q[k], 1'b0, 1'b0, 1'b0, o); ok &= o; end
    stuck = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (in_ready !== 1'b0) stuck = 1'b0;
    end
    checks++;
    if (!stuck || got_q.size() != 0) begin
      errors++; $display("FAIL bp_hold: in_ready stayed low %b, got %0d compresses required 1 0", stuck, got_q.size());
    end
    @(posedge clk); #1 hold = 1'b0;
    for (int k = 8; k < 11; k++) begin drive_beat(msg_q[k], k == 10, 1'b0, 1'b0, o); ok &= o; end
    wait_done(o); ok &= o;
    build_expected();
    checks++;
    bad = first_bad();
    if (!ok || bad != -1) begin
      errors++; $display("FAIL bp_words: ok %b mismatch code %0d, got %0d words required %0d", ok, bad, got_q.size(), exp_q.size());
    end
    checks++;
    if (msg_len !== 32'd11 || viol != 0) begin
      errors++; $display("FAIL bp_end: msg_len %0d viol %0d required 11 0", msg_len, viol);
    end
  endtask

  task automatic test_long();
    bit ok;
    int bad;
    run_msg(256, 1'b0, 1'b0, 1'b0, ok);
    bad = first_bad();
    checks++;
    if (!ok || bad != -1) begin
      errors++; $display("FAIL len256_words: ok %b mismatch code %0d", ok, bad);
    end else if (got_q[got_q.size() - 1] !== 64'h0) begin
      errors++; $display("FAIL len256_tail: got %h required 0", got_q[got_q.size() - 1]);
    end
    checks++;
    if (msg_len !== 32'd256 || msg_len_w !== 9'd256 || viol != 0) begin
      errors++; $display("FAIL len256_len: msg_len %0d narrow %0d viol %0d required 256 256 0", msg_len, msg_len_w, viol);
    end
    run_msg(515, 1'b0, 1'b0, 1'b1, ok);
    bad = first_bad();
    checks++;
    if (!ok || bad != -1) begin
      errors++; $display("FAIL len515_words: ok %b mismatch code %0d", ok, bad);
    end else if (got_q[got_q.size() - 1][63:56] !== 8'h03) begin
      errors++; $display("FAIL len515_pad: got %h required 03", got_q[got_q.size() - 1][63:56]);
    end
    checks++;
    if (msg_len !== 32'd515 || msg_len_w !== 9'd3 || viol != 0) begin
      errors++; $display("FAIL len515_wrap: msg_len %0d narrow %0d viol %0d required 515 3 0", msg_len, msg_len_w, viol);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, o;
    int bad;
    clear_mon();
    do_start(ok);
    for (int k = 0; k < 5; k++) begin drive_beat(8'($urandom), 1'b0, 1'b0, 1'b0, o); ok &= o; end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, core_initalize, core_compress, core_finalize, busy, done} !== 6'b0 ||
        msg_len !== 32'h0 || core_mi !== 64'h0 || !ok) begin
      errors++;
      $display("FAIL midreset_out: ctrl %b msg_len %0d mi %h ok %b required 000000 0 0 1",
               {in_ready, core_initalize, core_compress, core_finalize, busy, done}, msg_len, core_mi, ok);
    end
    @(negedge clk) reset_n = 1'b1;
    clear_mon();
    in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (init_cnt + got_q.size() + fin_cnt + done_cnt != 0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: pulses %0d busy %b in_ready %b required 0 0 0",
               init_cnt + got_q.size() + fin_cnt + done_cnt, busy, in_ready);
    end
    run_msg(21, 1'b0, 1'b0, 1'b1, ok);
    bad = first_bad();
    checks++;
    if (!ok || bad != -1 || msg_len !== 32'd21 || viol != 0) begin
      errors++; $display("FAIL midreset_rehash: ok %b mismatch code %0d msg_len %0d viol %0d required 1 -1 21 0", ok, bad, msg_len, viol);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty();
    test_vectors();
    test_random();
    test_backpressure();
    test_long();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
